// File: rtl/if_id_queue_pkg.sv
// Shared constants for the fetch queue: stall encoding, reset polarity, NOP word and bus widths.
package if_id_queue_pkg;

  localparam logic RstEnable    = 1'b0;
  localparam logic NoStop       = 1'b0;
  localparam logic Stop         = 1'b1;

  localparam int   InstAddrBusW = 32;
  localparam int   InstBusW     = 32;

  // sll $0,$0,0 encodes as the all-zero word
  localparam logic [InstBusW-1:0] NopInst = '0;

endpackage

// File: rtl/if_id_queue_fifo.sv
// Generic synchronous FIFO with clear; head entry is readable combinationally so the
// consumer can register it on the same edge that pops it.
module if_id_queue_fifo
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID boundary: fetch queue plus the registered ID-facing output, with flush, bubble
// and bypass handled around the FIFO.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = InstAddrBusW,
  parameter int DATA_W = InstBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [DATA_W-1:0] if_inst_i,
  input  logic [5:0]        stall,
  input  logic              flush_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid
);

  logic                     advance;
  logic                     bubble;
  logic                     push_req;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;
  logic [ADDR_W-1:0]        head_pc;
  logic [DATA_W-1:0]        head_inst;

  logic [ADDR_W-1:0]        id_pc_reg,    id_pc_next;
  logic [DATA_W-1:0]        id_inst_reg,  id_inst_next;
  logic                     id_valid_reg, id_valid_next;

  // Only the ID and EX hold bits matter here; the rest belong to other stages.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign advance  = (stall[1] == NoStop);
  assign bubble   = (stall[1] == Stop) && (stall[2] == NoStop);
  assign push_req = if_valid_i && !fifo_full && !flush_i;

  // An empty queue with ID advancing forwards the input straight to the output register.
  assign fifo_push = push_req && !(advance && fifo_empty);
  assign fifo_pop  = !flush_i && advance && !fifo_empty;

  assign {head_pc, head_inst} = fifo_dout;

  if_id_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush_i),
    .din   ({if_pc_i, if_inst_i}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    id_pc_next    = id_pc_reg;
    id_inst_next  = id_inst_reg;
    id_valid_next = id_valid_reg;
    if (flush_i || bubble) begin
      id_pc_next    = '0;
      id_inst_next  = DATA_W'(NopInst);
      id_valid_next = 1'b0;
    end else if (advance) begin
      if (!fifo_empty) begin
        id_pc_next    = head_pc;
        id_inst_next  = head_inst;
        id_valid_next = 1'b1;
      end else if (push_req) begin
        id_pc_next    = if_pc_i;
        id_inst_next  = if_inst_i;
        id_valid_next = 1'b1;
      end else begin
        id_pc_next    = '0;
        id_inst_next  = DATA_W'(NopInst);
        id_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
      id_valid_reg <= 1'b0;
    end else begin
      id_pc_reg    <= id_pc_next;
      id_inst_reg  <= id_inst_next;
      id_valid_reg <= id_valid_next;
    end
  end

  assign id_pc    = id_pc_reg;
  assign id_inst  = id_inst_reg;
  assign id_valid = id_valid_reg;
  assign full_o   = fifo_full;

endmodule
